// File: rtl/rr_queue_bank.sv
`default_nettype none
// ============================================================================
// Module   : rr_queue_bank
// Purpose  : Bank of three independent FIFO queues sharing one write port
//            and one pop port. The write port targets a queue by id; the pop
//            port is driven by an external round-robin scheduler through a
//            one-hot grant. Each popped entry appears on o_out_data one cycle
//            after the grant. Illegal grants, meaning more than one bit set
//            or a grant to an empty queue, raise a one-cycle error pulse.
//
// Ports    : clk          - single clock, rising edge
//            rst_n        - asynchronous active-low reset
//            i_in_vld     - write request
//            i_in_qid     - target queue of the write (0..2; 3 is ignored)
//            i_in_data    - write data
//            o_in_rdy     - targeted queue is not full (0 for qid 3)
//            o_q0_rdy..o_q2_rdy - queue n non-empty, from registered counts
//            i_sel        - one-hot pop grant (001=q0, 010=q1, 100=q2)
//            o_out_vld    - o_out_data holds a freshly popped entry
//            o_out_data   - popped entry; holds its value when nothing pops
//            o_drop_cnt   - saturating count of writes dropped on full queues
//                           (present only when RRQ_DROP_CNT_EN is defined)
//            o_sel_err    - one-cycle pulse for an illegal grant
//
// Options  : RRQ_DROP_CNT_EN - adds the o_drop_cnt port and its counter
//
// Revision : 1.0 - initial release
// ============================================================================
module rr_queue_bank #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_in_vld,
    input  logic [1:0]    i_in_qid,
    input  logic [DW-1:0] i_in_data,
    output logic          o_in_rdy,
    output logic          o_q0_rdy,
    output logic          o_q1_rdy,
    output logic          o_q2_rdy,
    input  logic [2:0]    i_sel,
    output logic          o_out_vld,
    output logic [DW-1:0] o_out_data,
`ifdef RRQ_DROP_CNT_EN
    output logic [7:0]    o_drop_cnt,
`endif
    output logic          o_sel_err
);

    // Pointer width indexes DEPTH entries. The count needs one extra bit so
    // that it can represent the full value DEPTH.
    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = c_PW + 1;

    logic [2:0]          w_full;
    logic [2:0]          w_nempty;
    logic [2:0]          w_wr;
    logic [2:0]          w_pop;
    logic [2:0][DW-1:0]  w_head;
    logic                w_sel_onehot;
    logic                w_sel_multi;
    logic                w_any_pop;
    logic [DW-1:0]       w_pop_data;

    logic                r_out_vld;
    logic [DW-1:0]       r_out_data;
    logic                r_sel_err;

    assign w_sel_onehot = (i_sel == 3'b001) || (i_sel == 3'b010) || (i_sel == 3'b100);
    assign w_sel_multi  = (i_sel != 3'b000) && !w_sel_onehot;

    // ------------------------------------------------------------------
    // Per-queue FIFO. Full and empty decisions come only from the
    // registered count. As a result, a write to a full queue is dropped
    // even when the same queue pops in that cycle. A pop from an empty
    // queue is refused even when the same queue is written in that cycle.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_queue
            logic [c_CW-1:0] r_cnt;
            logic [c_PW-1:0] r_wptr;
            logic [c_PW-1:0] r_rptr;
            logic [DW-1:0]   r_mem [DEPTH];

            assign w_full[gi]   = (r_cnt == c_CW'(DEPTH));
            assign w_nempty[gi] = (r_cnt != '0);
            assign w_wr[gi]     = i_in_vld && (i_in_qid == 2'(gi)) && !w_full[gi];
            assign w_pop[gi]    = w_sel_onehot && i_sel[gi] && w_nempty[gi];
            assign w_head[gi]   = r_mem[r_rptr];

            // DEPTH is a power of two, so the pointers wrap naturally.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt  <= '0;
                    r_wptr <= '0;
                    r_rptr <= '0;
                end else begin
                    if (w_wr[gi]) begin
                        r_wptr <= r_wptr + c_PW'(1);
                    end
                    if (w_pop[gi]) begin
                        r_rptr <= r_rptr + c_PW'(1);
                    end
                    case ({w_wr[gi], w_pop[gi]})
                        2'b10:   r_cnt <= r_cnt + c_CW'(1);
                        2'b01:   r_cnt <= r_cnt - c_CW'(1);
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end

            // Storage is not reset. Clearing the pointers and count on reset
            // is enough to discard the stored entries.
            always_ff @(posedge clk) begin
                if (w_wr[gi]) begin
                    r_mem[r_wptr] <= i_in_data;
                end
            end
        end
    endgenerate

    always_comb begin
        o_in_rdy = 1'b0;
        case (i_in_qid)
            2'd0:    o_in_rdy = !w_full[0];
            2'd1:    o_in_rdy = !w_full[1];
            2'd2:    o_in_rdy = !w_full[2];
            default: o_in_rdy = 1'b0;
        endcase
    end

    assign o_q0_rdy = w_nempty[0];
    assign o_q1_rdy = w_nempty[1];
    assign o_q2_rdy = w_nempty[2];

    always_comb begin
        w_pop_data = '0;
        for (int k = 0; k < 3; k++) begin
            if (w_pop[k]) begin
                w_pop_data = w_head[k];
            end
        end
    end

    assign w_any_pop = |w_pop;

    // Output stage. o_out_data keeps its last popped value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_sel_err  <= 1'b0;
        end else begin
            r_out_vld <= w_any_pop;
            r_sel_err <= w_sel_multi || (w_sel_onehot && !w_any_pop);
            if (w_any_pop) begin
                r_out_data <= w_pop_data;
            end
        end
    end

    assign o_out_vld  = r_out_vld;
    assign o_out_data = r_out_data;
    assign o_sel_err  = r_sel_err;

`ifdef RRQ_DROP_CNT_EN
    logic       w_drop;
    logic [7:0] r_drop_cnt;

    // A drop is a valid write with an in-range qid whose target is full.
    assign w_drop = i_in_vld && (i_in_qid != 2'd3) && !o_in_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_queue_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_queue_bank
// Purpose  : Self-checking bench for rr_queue_bank. A queue-based reference
//            model predicts every output on every cycle. Literal expectations
//            taken from the directed scenarios pin the model itself.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_queue_bank;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic [1:0]    in_qid = 2'd0;
    logic [DW-1:0] in_data = '0;
    logic [2:0]    sel = 3'b000;
    logic          in_rdy, q0_rdy, q1_rdy, q2_rdy, out_vld, sel_err;
    logic [DW-1:0] out_data;
`ifdef RRQ_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [DW-1:0] mq [3][$];
    logic          exp_vld  = 1'b0;
    logic [DW-1:0] exp_data = '0;
    logic          exp_err  = 1'b0;
    int            exp_drop = 0;

    rr_queue_bank #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in_vld   (in_vld),
        .i_in_qid   (in_qid),
        .i_in_data  (in_data),
        .o_in_rdy   (in_rdy),
        .o_q0_rdy   (q0_rdy),
        .o_q1_rdy   (q1_rdy),
        .o_q2_rdy   (q2_rdy),
        .i_sel      (sel),
        .o_out_vld  (out_vld),
        .o_out_data (out_data),
`ifdef RRQ_DROP_CNT_EN
        .o_drop_cnt (drop_cnt),
`endif
        .o_sel_err  (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_in_rdy();
        if (in_qid == 2'd3) return 0;
        return (mq[int'(in_qid)].size() < DEPTH) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int q = 0; q < 3; q++) mq[q].delete();
        exp_vld  = 1'b0;
        exp_data = '0;
        exp_err  = 1'b0;
        exp_drop = 0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        int            pidx = -1;
        int            qi;
        bit            err = 1'b0;
        logic [DW-1:0] pd = '0;
        int            n;
        n = $countones(sel);
        if (n > 1) begin
            err = 1'b1;
        end else if (n == 1) begin
            qi = sel[0] ? 0 : (sel[1] ? 1 : 2);
            if (mq[qi].size() > 0) pidx = qi;
            else err = 1'b1;
        end
        qi = int'(in_qid);
        if (pidx >= 0) pd = mq[pidx].pop_front();
        if (in_vld && in_qid != 2'd3) begin
            // Fullness is judged on occupancy before this edge's pop.
            if (mq[qi].size() + ((pidx == qi) ? 1 : 0) < DEPTH) mq[qi].push_back(in_data);
            else if (exp_drop < 255) exp_drop++;
        end
        exp_vld = (pidx >= 0);
        if (pidx >= 0) exp_data = pd;
        exp_err = err;
    endtask

    task automatic cycle(input logic v, input logic [1:0] q, input logic [DW-1:0] d,
                         input logic [2:0] s);
        @(negedge clk);
        in_vld  = v;
        in_qid  = q;
        in_data = d;
        sel     = s;
        @(posedge clk);
        model_step();
        #3;
    endtask

    // Per-cycle comparison against the model, between edges.
    always @(posedge clk) begin
        #2;
        if (chk_en && rst_n) begin
            chk("out_vld",  int'(out_vld),  int'(exp_vld));
            chk("out_data", int'(out_data), int'(exp_data));
            chk("sel_err",  int'(sel_err),  int'(exp_err));
            chk("q0_rdy",   int'(q0_rdy),   (mq[0].size() != 0) ? 1 : 0);
            chk("q1_rdy",   int'(q1_rdy),   (mq[1].size() != 0) ? 1 : 0);
            chk("q2_rdy",   int'(q2_rdy),   (mq[2].size() != 0) ? 1 : 0);
            chk("in_rdy",   int'(in_rdy),   exp_in_rdy());
`ifdef RRQ_DROP_CNT_EN
            chk("drop_cnt", int'(drop_cnt), exp_drop);
`endif
        end
    end

    function automatic logic [2:0] pat_sel(input int i);
        case (i % 6)
            0: return 3'b001;
            1: return 3'b000;
            2: return 3'b010;
            3: return 3'b100;
            4: return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    initial begin
        model_reset();
        #1;
        chk("rst_q0_rdy",   int'(q0_rdy),   0);
        chk("rst_q1_rdy",   int'(q1_rdy),   0);
        chk("rst_q2_rdy",   int'(q2_rdy),   0);
        chk("rst_in_rdy",   int'(in_rdy),   1);
        chk("rst_out_vld",  int'(out_vld),  0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_sel_err",  int'(sel_err),  0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Single write to q1, no grant
        cycle(1'b1, 2'd1, 8'hA1, 3'b000);
        chk("w_q1_rdy", int'(q1_rdy), 1);
        chk("w_q0_rdy", int'(q0_rdy), 0);
        chk("w_q2_rdy", int'(q2_rdy), 0);
        chk("w_out_vld", int'(out_vld), 0);
        cycle(1'b0, 2'd0, 8'h00, 3'b010);
        chk("pop_q1_data", int'(out_data), 8'hA1);

        // FIFO order on q0
        cycle(1'b1, 2'd0, 8'h11, 3'b000);
        cycle(1'b1, 2'd0, 8'h22, 3'b000);
        cycle(1'b0, 2'd0, 8'h00, 3'b001);
        chk("q0_first", int'(out_data), 8'h11);
        chk("q0_first_vld", int'(out_vld), 1);
        chk("q0_rdy_mid", int'(q0_rdy), 1);
        cycle(1'b0, 2'd0, 8'h00, 3'b001);
        chk("q0_second", int'(out_data), 8'h22);
        chk("q0_rdy_empty", int'(q0_rdy), 0);

        // Overfill q2
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2'd2, 8'h31 + 8'(i), 3'b000);
            if (i == 3) chk("q2_full_in_rdy", int'(in_rdy), 0);
        end
`ifdef RRQ_DROP_CNT_EN
        chk("drop_cnt_one", int'(drop_cnt), 1);
`endif
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 2'd2, 8'h00, 3'b100);
            chk("q2_drain", int'(out_data), 8'h31 + i);
        end
        chk("q2_empty", int'(q2_rdy), 0);

        // Full queue with a simultaneous write and pop: the pop wins
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'd2, 8'h41 + 8'(i), 3'b000);
        cycle(1'b1, 2'd2, 8'h45, 3'b100);
        chk("full_wp_data", int'(out_data), 8'h41);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'd2, 8'h00, 3'b100);
            chk("full_wp_drain", int'(out_data), 8'h42 + i);
        end
        cycle(1'b0, 2'd2, 8'h00, 3'b000);
        chk("full_wp_gone", int'(q2_rdy), 0);

        // Multi-bit grant
        cycle(1'b1, 2'd0, 8'h51, 3'b000);
        cycle(1'b1, 2'd1, 8'h52, 3'b000);
        cycle(1'b0, 2'd0, 8'h00, 3'b011);
        chk("multi_err", int'(sel_err), 1);
        chk("multi_vld", int'(out_vld), 0);
        chk("multi_q0", int'(q0_rdy), 1);
        chk("multi_q1", int'(q1_rdy), 1);
        cycle(1'b0, 2'd0, 8'h00, 3'b000);
        chk("idle_err_clear", int'(sel_err), 0);

        // Grant to an empty queue, then a write and a grant in the same cycle
        cycle(1'b0, 2'd0, 8'h00, 3'b100);
        chk("empty_err", int'(sel_err), 1);
        chk("empty_vld", int'(out_vld), 0);
        cycle(1'b1, 2'd2, 8'h77, 3'b100);
        chk("wp_empty_err", int'(sel_err), 1);
        chk("wp_empty_vld", int'(out_vld), 0);
        chk("wp_empty_q2", int'(q2_rdy), 1);
        cycle(1'b0, 2'd0, 8'h00, 3'b100);
        chk("wp_empty_pop", int'(out_data), 8'h77);

        // Write and pop together on a partially filled queue
        cycle(1'b1, 2'd0, 8'h61, 3'b001);
        chk("wp_mid_data", int'(out_data), 8'h51);
        chk("wp_mid_q0", int'(q0_rdy), 1);
        cycle(1'b0, 2'd0, 8'h00, 3'b001);
        chk("wp_mid_next", int'(out_data), 8'h61);
        cycle(1'b0, 2'd0, 8'h00, 3'b010);
        chk("q1_left", int'(out_data), 8'h52);

        // qid 3 write is ignored
        cycle(1'b1, 2'd3, 8'hEE, 3'b000);
        chk("qid3_in_rdy", int'(in_rdy), 0);
        chk("qid3_q0", int'(q0_rdy), 0);

        // Mixed directed pattern stream
        for (int i = 0; i < 48; i++) begin
            cycle((i % 3) != 0, 2'(i % 4), 8'(i * 7 + 3), pat_sel(i));
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 2'd0, 8'h00, 3'(1 << (i % 3)));

        // Reset in the middle of a pop sequence
        cycle(1'b1, 2'd0, 8'h81, 3'b000);
        cycle(1'b1, 2'd0, 8'h82, 3'b000);
        cycle(1'b1, 2'd0, 8'h83, 3'b000);
        cycle(1'b0, 2'd0, 8'h00, 3'b001);
        chk("pre_rst_pop", int'(out_data), 8'h81);
        @(negedge clk);
        sel = 3'b001;
        chk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_q0", int'(q0_rdy), 0);
        chk("rst_mid_vld", int'(out_vld), 0);
        chk("rst_mid_data", int'(out_data), 0);
        @(negedge clk);
        sel = 3'b000;
        rst_n = 1'b1;
        chk_en = 1'b1;
        cycle(1'b1, 2'd0, 8'h91, 3'b000);
        chk("post_rst_q0", int'(q0_rdy), 1);
        cycle(1'b0, 2'd0, 8'h00, 3'b001);
        chk("post_rst_pop", int'(out_data), 8'h91);
        chk("post_rst_q0_empty", int'(q0_rdy), 0);
        cycle(1'b0, 2'd0, 8'h00, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_queue_bank.md
RR_QUEUE_BANK -- requirements
Module: rr_queue_bank

Interface
REQ-001 Parameter DW, 8, data width in bits.
REQ-002 Parameter DEPTH, 4, entries per queue; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_vld  input  1  write request.
REQ-006 in_qid  input  2  target queue of write: 0, 1 or 2; value 3 invalid.
REQ-007 in_data  input  DW  write data.
REQ-008 in_rdy  output  1  target queue in_qid not full (combinational from registered counts).
REQ-009 q0_rdy, q1_rdy, q2_rdy  output  1 each  queue n non-empty; feeds the round-robin scheduler.
REQ-010 sel  input  3  one-hot grant from scheduler: 001=q0, 010=q1, 100=q2, 000=none.
REQ-011 out_vld  output  1  out_data valid this cycle.
REQ-012 out_data  output  DW  popped entry.
REQ-013 sel_err  output  1  one-cycle pulse: illegal sel or grant to an empty queue.

Function
REQ-014 Each queue SHALL be an independent FIFO of DEPTH entries: write pointer, read pointer, occupancy count (0..DEPTH).
REQ-015 Write accepted when in_vld=1, in_qid<=2, target count<DEPTH; entry stored at that queue's write pointer, pointer advances.
REQ-016 Write with in_qid=3 SHALL be ignored, no state change; in_rdy=0 for qid 3.
REQ-017 Write to a full queue SHALL be dropped; stored data unchanged.
REQ-018 qN_rdy SHALL equal (countN != 0) from registered count, no combinational path from in_* or sel.
REQ-019 Pop when sel is exactly one-hot and selected queue count>0; entry at read pointer is registered to out_data, out_vld=1 the next cycle (latency 1).
REQ-020 sel=000 SHALL cause no pop; out_vld=0 next cycle; out_data holds last value.
REQ-021 sel with more than one bit set SHALL cause no pop, out_vld=0 next cycle, sel_err=1 next cycle.
REQ-022 One-hot sel to an empty queue SHALL cause no pop, out_vld=0, sel_err=1 next cycle.
REQ-023 Simultaneous write and pop, same non-full, non-empty queue: both SHALL occur; count unchanged.
REQ-024 Simultaneous write and pop on full queue: pop occurs, write dropped (in_rdy already 0).
REQ-025 Simultaneous write and pop on empty queue: write occurs, no pop, sel_err=1; data visible after one cycle.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0; count SHALL never exceed DEPTH or go below 0.
REQ-027 At most one pop per cycle; FIFO order preserved per queue.

Reset
REQ-028 On rst_n low all counts and pointers SHALL clear immediately; q0_rdy=q1_rdy=q2_rdy=0, in_rdy=1 (for qid 0..2), out_vld=0, out_data=0, sel_err=0.
REQ-029 Reset mid-operation SHALL discard all stored entries; storage array need not be cleared.
REQ-030 First write SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro RRQ_DROP_CNT_EN: when defined, output drop_cnt (8 bits) SHALL count writes dropped per REQ-017, saturating at 255, reset to 0.
REQ-032 Without RRQ_DROP_CNT_EN the drop_cnt port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-033 Reset, then write 0xA1 to q1, sel=000 -> q1_rdy=1 next cycle; q0_rdy=q2_rdy=0; out_vld=0.
REQ-034 Write 0x11,0x22 to q0, then sel=001 for two cycles -> out_data 0x11 then 0x22 with out_vld=1, q0_rdy falls after second pop, order preserved.
REQ-035 Write 5 entries to q2 (DEPTH=4) -> in_rdy=0 with qid=2 after 4th, 5th dropped; drop_cnt=1 if RRQ_DROP_CNT_EN; pops return first 4 only.
REQ-036 sel=011 with q0,q1 non-empty -> no pop, counts unchanged, sel_err=1, out_vld=0 next cycle.
REQ-037 sel=100 with q2 empty -> sel_err=1, out_vld=0; then write plus sel=100 same cycle on empty q2 -> no pop that cycle, pop of written value next grant.
REQ-038 Fill q0 with 3 entries, assert rst_n low mid-pop -> q0_rdy=0, out_vld=0 immediately; after release q0 empty, write to q0 accepted.
